uart_byte_fifo: RTL and testbench

- Elastic byte buffer between the UART receiver and the UART transmitter.
- Accepts single-cycle byte strobes from the receiver and stores them in a circular FIFO.
- Replays bytes to the transmitter one at a time, pacing each release on the transmitter's busy flag.
- Prevents back-to-back received bytes from being lost while the transmitter is still shifting out the previous byte.

---
 rtl/uart_byte_fifo.sv | 115 +++++++++++
 tb/tb_uart_byte_fifo.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_fifo.sv
// Elastic byte FIFO between UART RX and TX: stores receiver strobes in a circular
// buffer and releases one byte at a time, paced by the transmitter's busy flag.
module uart_byte_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int ACK_TO = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_vld,
    input  logic              tx_busy,
    input  logic              ovf_clr,
    output logic [DATA_W-1:0] dout,
    output logic              dout_vld,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overflow
);

    localparam int TO_W = $clog2(ACK_TO) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count_nxt;
    logic [TO_W-1:0]   to_cnt, to_inc;
    state_t            state;
    logic              pop, wr, drop;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a write then.
    assign pop    = (state == IDLE) && !empty && !tx_busy;
    assign wr     = din_vld && (!full || pop);
    assign drop   = din_vld && full && !pop;
    assign to_inc = to_cnt + 1'b1;

    always_comb begin
        count_nxt = count;
        if (wr && !pop)
            count_nxt = count + 1'b1;
        else if (pop && !wr)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (wr)
                wr_ptr <= wr_ptr + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == (ADDR_W+1)'(DEPTH));
            empty <= (count_nxt == '0);
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rd_ptr   <= '0;
            dout     <= '0;
            dout_vld <= 1'b0;
            to_cnt   <= '0;
        end else begin
            dout_vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        dout     <= mem[rd_ptr];
                        rd_ptr   <= rd_ptr + 1'b1;
                        dout_vld <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    to_cnt <= '0;
                    state  <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    // Give up waiting for busy so a silent transmitter cannot stall the queue.
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else begin
                        to_cnt <= to_inc;
                        if (to_inc >= TO_W'(ACK_TO - 1))
                            state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_byte_fifo.sv
// Scoreboard bench for uart_byte_fifo: stimulus queues expected bytes, a negedge
// monitor pops and compares on every dout_vld pulse.
module tb_uart_byte_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    // ACK_TO=2 makes the timeout path a single WAIT_ACK cycle: four-cycle issue spacing.
    localparam int ACK_TO = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] din = '0;
    logic              din_vld = 1'b0;
    logic              tx_busy = 1'b0;
    logic              ovf_clr = 1'b0;
    logic [DATA_W-1:0] dout;
    logic              dout_vld;
    logic [ADDR_W:0]   count;
    logic              full, empty, overflow;

    uart_byte_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .ACK_TO(ACK_TO)) dut (
        .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .tx_busy(tx_busy),
        .ovf_clr(ovf_clr), .dout(dout), .dout_vld(dout_vld), .count(count),
        .full(full), .empty(empty), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic gap_chk = 1'b0;
    int   last_vld = -1;
    logic prev_vld = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every issued byte must match the head of the scoreboard.
    always @(negedge clk) begin
        if (dout_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_dout_vld", {24'h0, dout}, 32'hFFFF_FFFF);
            end else begin
                chk("dout_order", {24'h0, dout}, {24'h0, exp_q.pop_front()});
            end
            chk("vld_not_back_to_back", {31'h0, prev_vld}, 32'h0);
            if (gap_chk && last_vld >= 0)
                chk("vld_spacing", cyc - last_vld, 4);
            last_vld = cyc;
        end
        prev_vld = dout_vld;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DATA_W-1:0] b, input bit expect_kept);
        din = b;
        din_vld = 1'b1;
        if (expect_kept) exp_q.push_back(b);
        tick();
        din_vld = 1'b0;
    endtask

    // Transmitter model: one busy pulse of 5 cycles per issued byte.
    task automatic drain(input int n);
        for (int k = 0; k < n; k++) begin
            int w;
            tx_busy = 1'b0;
            w = 0;
            while (dout_vld !== 1'b1 && w < 20) begin
                tick();
                w++;
            end
            if (dout_vld !== 1'b1) chk("drain_timeout", w, 0);
            tick();
            tx_busy = 1'b1;
            repeat (5) tick();
            tx_busy = 1'b0;
        end
        repeat (3) tick();
    endtask

    task automatic wait_empty();
        int w = 0;
        while (exp_q.size() != 0 && w < 400) begin
            tick();
            w++;
        end
        chk("scoreboard_drained", exp_q.size(), 0);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        tick(); tick();
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_dout", dout, 0);
        chk("rst_dout_vld", dout_vld, 0);
        rst = 1'b0;
        tick();

        // Reset mid-stream with 5 stored bytes; none may come out later
        tx_busy = 1'b1;
        for (int i = 0; i < 5; i++) push(8'hE0 + 8'(i), 1'b1);
        chk("mid_count5", count, 5);
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        exp_q.delete();
        chk("mid_rst_count", count, 0);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_vld", dout_vld, 0);
        chk("mid_rst_ovf", overflow, 0);
        tx_busy = 1'b0;
        repeat (10) tick();
        chk("mid_rst_still_empty", count, 0);

        // Single byte latency, long busy, return to IDLE after busy falls
        push(8'hA5, 1'b1);
        chk("single_empty_n1", empty, 0);
        chk("single_vld_n1", dout_vld, 0);
        tick();
        chk("single_vld_n2", dout_vld, 1);
        chk("single_dout_n2", dout, 8'hA5);
        tick();
        tx_busy = 1'b1;
        repeat (100) tick();
        chk("single_dout_hold", dout, 8'hA5);
        tx_busy = 1'b0;
        push(8'h3C, 1'b1);
        tick();
        chk("idle_after_busy_vld", dout_vld, 1);
        repeat (6) tick();

        // Burst of 20 while busy: 16 kept, 4 dropped, FIFO order on release
        tx_busy = 1'b1;
        for (int i = 0; i < 20; i++) push(8'(i), i < 16);
        chk("burst_count", count, 16);
        chk("burst_full", full, 1);
        chk("burst_overflow", overflow, 1);
        chk("burst_empty", empty, 0);
        drain(16);
        chk("burst_drained", exp_q.size(), 0);
        chk("burst_count0", count, 0);

        // Full FIFO with a write landing on the pop cycle
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_cleared", overflow, 0);
        tx_busy = 1'b1;
        for (int i = 0; i < 16; i++) push(8'h40 + 8'(i), 1'b1);
        chk("simul_full_before", full, 1);
        tx_busy = 1'b0;
        push(8'h99, 1'b1);
        chk("simul_count", count, 16);
        chk("simul_full", full, 1);
        chk("simul_overflow", overflow, 0);
        chk("simul_vld", dout_vld, 1);
        drain(17);
        chk("simul_count0", count, 0);

        // Wrap-around: 40 bytes at a pace the consumer keeps up with
        tx_busy = 1'b0;
        for (int i = 0; i < 40; i++) begin
            push(8'(i * 7 + 3), 1'b1);
            for (int j = 0; j < 3; j++) begin
                chk("wrap_count_le3", {31'h0, (count <= 3)}, 1);
                tick();
            end
        end
        wait_empty();
        chk("wrap_count0", count, 0);

        // Timeout path spacing with busy tied low
        gap_chk = 1'b1;
        last_vld = -1;
        for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i), 1'b1);
        wait_empty();
        repeat (4) tick();
        gap_chk = 1'b0;

        // Drop coinciding with clear keeps overflow; clear alone releases it
        tx_busy = 1'b1;
        for (int i = 0; i < 16; i++) push(8'h70 + 8'(i), 1'b1);
        din = 8'hFF;
        din_vld = 1'b1;
        ovf_clr = 1'b1;
        tick();
        din_vld = 1'b0;
        chk("drop_and_clr_ovf", overflow, 1);
        tick();
        ovf_clr = 1'b0;
        chk("clr_alone_ovf", overflow, 0);
        drain(16);
        chk("final_count", count, 0);
        chk("final_empty", empty, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: sim time exceeded");
        $fatal(1, "timeout");
    end

endmodule
